// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift sequencer: FSM state encodings.
package shiftreg_pkg;

  // Encoding 2'd3 is unused and recovers to IDLE in the next-state logic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shiftreg_dp.sv
// WIDTH-bit shift register datapath: parallel load, or right shift with ser_in entering at the MSB.
module shiftreg_dp #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] sreg
);

  logic [WIDTH-1:0] sreg_reg;

  // Load wins over shift; the controller never asserts both together.
  always_ff @(posedge clk) begin
    if (rst) begin
      sreg_reg <= '0;
    end else if (load) begin
      sreg_reg <= load_data;
    end else if (shift_en) begin
      sreg_reg <= {ser_in, sreg_reg[WIDTH-1:1]};
    end
  end

  assign sreg = sreg_reg;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift sequencer: loads a value, shifts it out LSB-first a requested number of times, then pulses done.
module shift_seq_ctrl
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    shift_cnt,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out,
  output logic             busy,
  output logic             done
);

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            load;
  logic            shift;
  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    shift      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          load     = 1'b1;
          // Requests longer than the register saturate to WIDTH shifts.
          cnt_next = (shift_cnt > CW'(WIDTH)) ? CW'(WIDTH) : shift_cnt;
          state_next = (shift_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (shift_en) begin
          shift    = 1'b1;
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  shiftreg_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(load_data),
    .shift_en (shift),
    .ser_in   (ser_in),
    .sreg     (sreg)
  );

  // Status flags come straight from the state register, never from inputs.
  assign busy    = (state_reg == SHIFT);
  assign done    = (state_reg == DONE);
  assign ser_out = sreg[0];
  assign par_out = sreg;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=4); done-time par_out is scoreboarded by a monitor.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int CW    = 3;

  logic             clk;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] load_data;
  logic [CW-1:0]    shift_cnt;
  logic             shift_en;
  logic             ser_in;
  logic             ser_out;
  logic [WIDTH-1:0] par_out;
  logic             busy;
  logic             done;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] exp_q[$];

  shift_seq_ctrl #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .load_data(load_data),
    .shift_cnt(shift_cnt),
    .shift_en (shift_en),
    .ser_in   (ser_in),
    .ser_out  (ser_out),
    .par_out  (par_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every done pulse must match the oldest expected par_out.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done=1 par_out=%b expected no done", par_out);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (par_out !== e) begin
          errors++;
          $display("FAIL done_par_out: got %b expected %b", par_out, e);
        end else begin
          $display("ok   done_par_out: %b", par_out);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nbusy;
    bit seen;
    logic [3:0] v;

    rst = 1'b1; start = 1'b0; load_data = '0; shift_cnt = '0; shift_en = 1'b0; ser_in = 1'b0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_par", par_out, 0);
    chk("rst_ser", ser_out, 0);
    rst = 1'b0;
    step();

    // Full 4-shift job, ser_in=0.
    v = 4'b1011;
    start = 1; load_data = v; shift_cnt = 4; ser_in = 0; shift_en = 1;
    exp_q.push_back(4'b0000);
    step();
    start = 0;
    chk("t1_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_ser%0d", i + 1), ser_out, v[i]);
      step();
    end
    chk("t1_done", done, 1);
    chk("t1_par", par_out, 4'b0000);
    step();
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_done", done, 0);

    // Two shifts with ser_in=1.
    start = 1; load_data = 4'b1011; shift_cnt = 2; ser_in = 1;
    exp_q.push_back(4'b1110);
    step();
    start = 0;
    step();
    chk("t2_par1", par_out, 4'b1101);
    chk("t2_nodone1", done, 0);
    step();
    chk("t2_done", done, 1);
    chk("t2_par2", par_out, 4'b1110);
    step();
    chk("t2_hold", par_out, 4'b1110);
    step();

    // Zero count: straight to DONE.
    start = 1; load_data = 4'b0110; shift_cnt = 0;
    exp_q.push_back(4'b0110);
    step();
    start = 0;
    chk("t3_busy0", busy, 0);
    chk("t3_done", done, 1);
    chk("t3_par", par_out, 4'b0110);
    step();
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_done", done, 0);

    // Saturation: count 7 must give exactly 4 shifts.
    start = 1; load_data = 4'b0000; shift_cnt = 7; ser_in = 1;
    exp_q.push_back(4'b1111);
    step();
    start = 0;
    nbusy = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (busy) nbusy++;
      if (done) seen = 1;
      else step();
    end
    chk("t3_sat_done_seen", seen, 1);
    chk("t3_sat_nbusy", nbusy, 4);
    chk("t3_sat_par", par_out, 4'b1111);
    step(); step();

    // Stall for 3 cycles after the second shift.
    start = 1; load_data = 4'b1011; shift_cnt = 4; ser_in = 0; shift_en = 1;
    exp_q.push_back(4'b0000);
    step();
    start = 0;
    step(); step();
    chk("t4_par2", par_out, 4'b0010);
    shift_en = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t4_stall_par%0d", i), par_out, 4'b0010);
      chk($sformatf("t4_stall_busy%0d", i), busy, 1);
    end
    shift_en = 1;
    step();
    chk("t4_par6", par_out, 4'b0001);
    chk("t4_nodone6", done, 0);
    step();
    chk("t4_done7", done, 1);
    step(); step();

    // start during SHIFT and DONE is ignored.
    start = 1; load_data = 4'b1100; shift_cnt = 2; ser_in = 0;
    exp_q.push_back(4'b0011);
    step();
    load_data = 4'b1111; shift_cnt = 4;
    step();
    chk("t5_par1", par_out, 4'b0110);
    step();
    chk("t5_done", done, 1);
    chk("t5_par2", par_out, 4'b0011);
    step();
    start = 0;
    chk("t5_idle_busy", busy, 0);
    chk("t5_idle_par", par_out, 4'b0011);
    step();
    chk("t5_still_idle", busy, 0);

    // Reset mid-shift, with start and shift_en high to test priority.
    start = 1; load_data = 4'b1011; shift_cnt = 4; ser_in = 0; shift_en = 1;
    step();
    start = 0;
    step(); step();
    chk("t6_par2", par_out, 4'b0010);
    rst = 1; start = 1;
    step();
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_par", par_out, 0);
    rst = 0; load_data = 4'b1111; shift_cnt = 1; ser_in = 0;
    exp_q.push_back(4'b0111);
    step();
    start = 0;
    chk("t6_busy", busy, 1);
    step();
    chk("t6_done", done, 1);
    chk("t6_par", par_out, 4'b0111);
    step(); step();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
